sram_frame_fetch: RTL
=====================

Name: sram_frame_fetch

Overview:
- Upstream feeder for the display path.
- Sequences reads of a 16-bit frame buffer in external async SRAM and pushes each word into the pixel FIFO write port, throttled by that FIFO's full flag.
- Also arbitrates SRAM writes from game logic (sprite/maze updates) into the gaps between reads, with guaranteed write progress.
- Owns the shared tri-state SRAM data bus and all SRAM strobes.

Parameters:
- FRAME_WORDS, 19200: words per frame; read address wraps after FRAME_WORDS-1.
- READ_WAIT, 2: extra cycles oe_n is held low before data capture (SRAM access time), range 0..7.
- BASE_ADDR, 0: SRAM address of frame word 0.

Ports:
- clk  in  1  system clock (pixel-domain clock of the fetch side).
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse; restart fetch at word 0 (vsync-aligned).
- fifo_full  in  1  pixel FIFO full flag.
- fifo_wr  out  1  one-cycle FIFO write strobe.
- fifo_din  out  16  word written to FIFO, valid while fifo_wr=1.
- wr_req  in  1  game-logic write request; held until wr_ack.
- wr_addr  in  16  write address, stable while wr_req=1.
- wr_data  in  16  write data, stable while wr_req=1.
- wr_ack  out  1  one-cycle pulse when the write completes.
- sram_addr  out  16  SRAM address.
- sram_data  inout  16  SRAM data bus; driven only during write states, else Z.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.
- frame_done  out  1  high once all FRAME_WORDS words are pushed; cleared by frame_start.

Behaviour:
- Reset values (async, reset=0): state IDLE; sram_ce_n=sram_oe_n=sram_we_n=1; sram_addr=0; sram_data=Z; fifo_wr=0; fifo_din=0; wr_ack=0; frame_done=1 (idle until first frame_start); read pointer=0; last_was_read=0.
- States: IDLE, RD_SETUP, RD_WAIT, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD.
- IDLE arbitration, evaluated each cycle:
  - Read eligible = !frame_done && !fifo_full.
  - Write eligible = wr_req.
  - Both eligible: write goes if last_was_read=1, otherwise read goes (strict alternation, no starvation).
  - Neither eligible: stay in IDLE with ce_n=1.
- Read sequence:
  - RD_SETUP: sram_addr=BASE_ADDR+ptr, ce_n=0, oe_n=0.
  - RD_WAIT: READ_WAIT cycles (skipped when 0).
  - RD_CAP: capture sram_data into fifo_din.
  - If fifo_full=0 in RD_CAP: fifo_wr=1 that cycle, ptr increments, return to IDLE.
  - If fifo_full=1: hold in RD_CAP with oe_n=0 and the word latched; push on the first cycle fifo_full=0. A word is never dropped or duplicated.
  - Unstalled read = READ_WAIT+3 cycles from IDLE decision to fifo_wr.
- Write sequence:
  - WR_SETUP: addr=wr_addr, data driven, ce_n=0, we_n=1.
  - WR_PULSE: we_n=0.
  - WR_HOLD: we_n=1, data still driven, wr_ack=1; then IDLE.
  - oe_n=1 throughout. Bus is driven only in these three states.
- Pointer wrap: the push of word FRAME_WORDS-1 sets frame_done=1 and ptr=0; reads stop; writes continue.
- frame_start:
  - In IDLE: ptr=0, frame_done=0 on the next cycle.
  - Mid-access: latched. The current access completes, and its push still occurs. Then ptr=0 and frame_done=0 before the next arbitration.
  - frame_start coincident with the last-word push: restart wins (frame_done=0, ptr=0).
- No SRAM strobe ever changes while the address changes: address is set in SETUP, strobes change afterwards.
- reset asserted mid-operation: immediate return to reset values; bus released to Z asynchronously.

Optional Feature:
- Macro: FETCH_CHECKSUM_EN.
- Defined:
  - Adds output frame_sum [15:0].
  - A 16-bit running XOR of every word pushed in the current frame is cleared to 0 on frame_start.
  - frame_sum is updated with the final XOR when frame_done rises, and is held until the next completed frame.
  - Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: hold reset=0 with random inputs -> all strobes 1, sram_data Z, fifo_wr=0, frame_done=1.
- FRAME_WORDS=4, READ_WAIT=2, SRAM preloaded 0x1111..0x4444, fifo_full=0, one frame_start -> four fifo_wr pulses 5 cycles apart, carrying 0x1111, 0x2222, 0x3333, 0x4444; then frame_done=1 and no further reads.
- fifo_full=1 asserted during RD_WAIT of word 1 for 10 cycles -> oe_n held low in RD_CAP, exactly one push of 0x2222 after release, no duplicate.
- wr_req held (addr 0x0002, data 0xBEEF) during a continuous frame read -> reads and writes alternate; we_n low exactly 1 cycle; wr_ack pulses once; a subsequent frame reads 0xBEEF at word 2.
- frame_start pulsed during RD_WAIT of word 2 -> word 2 still pushed, next read address = BASE_ADDR+0, frame_done stays 0.
- FETCH_CHECKSUM_EN defined with the 4-word frame above -> frame_sum = 0x1111^0x2222^0x3333^0x4444 = 0x4444 when frame_done rises.

Source files
------------

// File: rtl/sram_frame_fetch_if.sv
// sram_frame_fetch_if: pixel FIFO write port plus game-logic SRAM write request
interface sram_frame_fetch_if;
  logic fifo_full;
  logic fifo_wr;
  logic [15:0] fifo_din;
  logic wr_req;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic wr_ack;
  modport master (input fifo_full, wr_req, wr_addr, wr_data, output fifo_wr, fifo_din, wr_ack);
  modport slave (output fifo_full, wr_req, wr_addr, wr_data, input fifo_wr, fifo_din, wr_ack);
endinterface

// File: rtl/sram_frame_fetch.sv
// sram_frame_fetch: frame-buffer read sequencer into the pixel FIFO with interleaved game writes; FETCH_CHECKSUM_EN adds frame_sum
module sram_frame_fetch #(
  parameter int FRAME_WORDS = 19200,
  parameter int READ_WAIT = 2,
  parameter int BASE_ADDR = 0
) (
  input logic clk,
  input logic reset,
  input logic frame_start,
  sram_frame_fetch_if.master bus,
  output logic [15:0] sram_addr,
  inout wire [15:0] sram_data,
  output logic sram_ce_n,
  output logic sram_oe_n,
  output logic sram_we_n,
  output logic frame_done
`ifdef FETCH_CHECKSUM_EN
  ,
  output logic [15:0] frame_sum
`endif
);
  typedef enum logic [2:0] {IDLE, RD_SETUP, RD_WAIT, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
  localparam logic [15:0] LAST = 16'(FRAME_WORDS - 1);
  localparam logic [2:0] WAIT_LAST = 3'(READ_WAIT > 0 ? READ_WAIT - 1 : 0);
  state_t state, state_nx;
  logic [15:0] ptr;
  logic [2:0] cnt;
  logic last_was_read, pend, held;
  logic restart, rd_ok, go_rd, go_wr, push, apply, last_word;
  logic [15:0] cap_word;
  assign restart = frame_start | pend;
  assign rd_ok = !frame_done && !bus.fifo_full && !restart;
  assign push = state == RD_CAP && !bus.fifo_full;
  // a pending restart lands only between accesses so the in-flight word still completes
  assign apply = restart && (state == IDLE || push || state == WR_HOLD);
  assign last_word = ptr == LAST;
  assign cap_word = held ? bus.fifo_din : sram_data;
  assign sram_ce_n = state == IDLE;
  assign sram_oe_n = !(state inside {RD_SETUP, RD_WAIT, RD_CAP});
  assign sram_we_n = state != WR_PULSE;
  assign bus.wr_ack = state == WR_HOLD;
  assign sram_data = state inside {WR_SETUP, WR_PULSE, WR_HOLD} ? bus.wr_data : 16'bz;
  always_comb begin
    state_nx = state;
    go_rd = 1'b0;
    go_wr = 1'b0;
    case (state)
      IDLE: begin
        go_wr = bus.wr_req && (last_was_read || !rd_ok);
        go_rd = rd_ok && !go_wr;
        state_nx = go_wr ? WR_SETUP : go_rd ? RD_SETUP : IDLE;
      end
      RD_SETUP: state_nx = READ_WAIT == 0 ? RD_CAP : RD_WAIT;
      RD_WAIT:  state_nx = cnt == WAIT_LAST ? RD_CAP : RD_WAIT;
      RD_CAP:   state_nx = bus.fifo_full ? RD_CAP : IDLE;
      WR_SETUP: state_nx = WR_PULSE;
      WR_PULSE: state_nx = WR_HOLD;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sram_addr <= 16'd0;
      bus.fifo_wr <= 1'b0;
      bus.fifo_din <= 16'd0;
      frame_done <= 1'b1;
      ptr <= 16'd0;
      cnt <= 3'd0;
      last_was_read <= 1'b0;
      pend <= 1'b0;
      held <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state == RD_WAIT ? cnt + 3'd1 : 3'd0;
      held <= state == RD_CAP && bus.fifo_full;
      bus.fifo_wr <= push;
      if (state == RD_CAP) bus.fifo_din <= cap_word;
      if (go_rd) begin
        sram_addr <= 16'(BASE_ADDR) + ptr;
        last_was_read <= 1'b1;
      end
      if (go_wr) begin
        sram_addr <= bus.wr_addr;
        last_was_read <= 1'b0;
      end
      if (apply) begin
        ptr <= 16'd0;
        frame_done <= 1'b0;
        pend <= 1'b0;
      end else begin
        pend <= restart;
        if (push) begin
          ptr <= last_word ? 16'd0 : ptr + 16'd1;
          if (last_word) frame_done <= 1'b1;
        end
      end
    end
  end
`ifdef FETCH_CHECKSUM_EN
  logic [15:0] sum_run;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_run <= 16'd0;
      frame_sum <= 16'd0;
    end else if (apply) begin
      sum_run <= 16'd0;
    end else if (push) begin
      sum_run <= sum_run ^ cap_word;
      if (last_word) frame_sum <= sum_run ^ cap_word;
    end
  end
`endif
endmodule
